hsv_core_mem_request: RTL

Issue stage of the hsv_core memory unit, directly upstream of the memory response stage. Takes one decoded load/store per handshake and checks alignment. Computes byte strobes, the write-data lane shift, the read shift and the memory/I-O classification. Drives the AXI AR/AW/W channels under ordering rules enforced by outstanding-read/write counters, then hands a `read_write_t` descriptor to the response stage. Owns post-flush draining of orphaned AXI responses.

---
 rtl/hsv_core_pkg.sv | 41 ++++
 rtl/hsv_core_mem_request_counter.sv | 31 +++
 rtl/hsv_core_mem_request.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv_core memory unit: request/descriptor structs,
// size/direction encodings and the outstanding-transaction counter type.
package hsv_core_pkg;

    localparam int MEM_COUNTER_W = 3;

    typedef logic [MEM_COUNTER_W-1:0] mem_counter;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } mem_dir_t;

    typedef struct packed {
        logic [7:0]  common;
        mem_dir_t    direction;
        mem_size_t   size;
        logic        sign_extend;
        logic [31:0] address;
        logic [31:0] write_data;
    } mem_data_t;

    typedef struct packed {
        mem_data_t   mem_data;
        logic        is_memory;
        logic        unaligned_address;
        logic [1:0]  read_shift;
    } read_write_t;

    function automatic logic is_unaligned(mem_size_t size, logic [1:0] offset);
        return ((size == SIZE_HALF) && offset[0]) ||
               ((size == SIZE_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/hsv_core_mem_request_counter.sv
// Outstanding AXI transaction counter; increments and decrements in the
// same cycle cancel, and the value never wraps in either direction.
module hsv_core_mem_counter
    import hsv_core_pkg::*;
(
    input  logic                     clk_core,
    input  logic                     rst_core_n,
    input  logic                     flush,
    input  logic                     up,
    input  logic                     down,
    output logic [MEM_COUNTER_W-1:0] count,
    output logic                     is_zero,
    output logic                     is_full
);

    assign is_zero = (count == '0);
    assign is_full = &count;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (up && !down && !is_full) begin
            count <= count + 1'b1;
        end else if (down && !up && !is_zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hsv_core_mem_request.sv
// Memory unit issue stage: captures one load/store, drives AXI AR/AW/W under
// read/write ordering rules, hands a descriptor to the response stage.
module hsv_core_mem_request
    import hsv_core_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'hF000_0000,
    parameter logic [31:0] IO_MASK = 32'hF000_0000
) (
    input  logic        clk_core,
    input  logic        rst_core_n,
    input  logic        flush,
    output logic        request_stall,
    input  mem_data_t   mem_data,
    input  logic        valid_i,
    input  logic        response_stall,
    output read_write_t response,
    output logic        valid_o,
    input  logic        pending_reads_down,
    input  logic        pending_writes_down,
    output logic        dmem_ar_valid,
    input  logic        dmem_ar_ready,
    output logic [31:0] dmem_ar_addr,
    output logic        dmem_aw_valid,
    input  logic        dmem_aw_ready,
    output logic [31:0] dmem_aw_addr,
    output logic        dmem_w_valid,
    input  logic        dmem_w_ready,
    output logic [31:0] dmem_w_data,
    output logic [3:0]  dmem_w_strb,
    output logic        drain_r_ready,
    output logic        drain_b_ready
);

    // state   | meaning
    // IDLE    | no request held, accepting
    // ISSUE   | AXI address/data handshakes in progress
    // HANDOFF | descriptor presented, waiting for the response stage
    // DRAIN   | post-flush, sinking orphaned R/B beats until counters are zero
    typedef enum logic [1:0] {IDLE, ISSUE, HANDOFF, DRAIN} state_t;

    state_t      state;
    read_write_t slot;
    read_write_t next_slot;
    logic [31:0] w_data, next_w_data;
    logic [3:0]  w_strb, next_w_strb;
    logic        aw_done, w_done, issued, flush_pending;

    logic [MEM_COUNTER_W-1:0] pending_reads, pending_writes;
    logic reads_zero, reads_full, writes_zero, writes_full;

    logic is_read, gate_open, go, any_raised;
    logic ar_fire, aw_fire, w_fire, issue_done;

    always_comb begin
        next_slot.mem_data          = mem_data;
        next_slot.is_memory         = ((mem_data.address & IO_MASK) != IO_BASE);
        next_slot.unaligned_address = is_unaligned(mem_data.size, mem_data.address[1:0]);
        next_slot.read_shift        = mem_data.address[1:0];
        next_w_data = mem_data.write_data << {mem_data.address[1:0], 3'b000};
        case (mem_data.size)
            SIZE_BYTE: next_w_strb = 4'b0001 << mem_data.address[1:0];
            SIZE_HALF: next_w_strb = 4'b0011 << mem_data.address[1:0];
            default:   next_w_strb = 4'hF;
        endcase
    end

    assign is_read = (slot.mem_data.direction == DIR_READ);

    always_comb begin
        if (!slot.is_memory) begin
            gate_open = reads_zero && writes_zero;
        end else if (is_read) begin
            gate_open = writes_zero && !reads_full;
        end else begin
            gate_open = !writes_full;
        end
    end

    // An I/O write bumps pending_writes on AW, which would re-close its own
    // gate while W is still owed; 'issued' keeps the raised valids up.
    assign go         = (state == ISSUE) && (gate_open || issued);
    assign any_raised = go;

    assign dmem_ar_valid = go && is_read;
    assign dmem_aw_valid = go && !is_read && !aw_done;
    assign dmem_w_valid  = go && !is_read && !w_done;

    assign ar_fire = dmem_ar_valid && dmem_ar_ready;
    assign aw_fire = dmem_aw_valid && dmem_aw_ready;
    assign w_fire  = dmem_w_valid && dmem_w_ready;

    assign issue_done = is_read ? ar_fire
                                : ((aw_done || aw_fire) && (w_done || w_fire));

    assign dmem_ar_addr = {slot.mem_data.address[31:2], 2'b00};
    assign dmem_aw_addr = {slot.mem_data.address[31:2], 2'b00};
    assign dmem_w_data  = w_data;
    assign dmem_w_strb  = w_strb;
    assign response     = slot;

    assign request_stall = !((state == IDLE) || ((state == HANDOFF) && !response_stall));

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state         <= IDLE;
            slot          <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            issued        <= 1'b0;
            flush_pending <= 1'b0;
            valid_o       <= 1'b0;
            drain_r_ready <= 1'b0;
            drain_b_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, HANDOFF: begin
                    if (flush) begin
                        state         <= DRAIN;
                        valid_o       <= 1'b0;
                        drain_r_ready <= 1'b1;
                        drain_b_ready <= 1'b1;
                    end else if (state == IDLE || !response_stall) begin
                        if (valid_i) begin
                            slot          <= next_slot;
                            w_data        <= next_w_data;
                            w_strb        <= next_w_strb;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            issued        <= 1'b0;
                            flush_pending <= 1'b0;
                            state         <= next_slot.unaligned_address ? HANDOFF : ISSUE;
                            valid_o       <= next_slot.unaligned_address;
                        end else begin
                            state   <= IDLE;
                            valid_o <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire) w_done <= 1'b1;
                    if (any_raised) issued <= 1'b1;
                    if ((flush && !any_raised) ||
                        (issue_done && (flush || flush_pending))) begin
                        state         <= DRAIN;
                        drain_r_ready <= 1'b1;
                        drain_b_ready <= 1'b1;
                    end else if (issue_done) begin
                        state   <= HANDOFF;
                        valid_o <= 1'b1;
                    end else if (flush) begin
                        flush_pending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (reads_zero && writes_zero) begin
                        state         <= IDLE;
                        drain_r_ready <= 1'b0;
                        drain_b_ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hsv_core_mem_counter u_pending_reads (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .flush      (1'b0),
        .up         (ar_fire),
        .down       (pending_reads_down),
        .count      (pending_reads),
        .is_zero    (reads_zero),
        .is_full    (reads_full)
    );

    hsv_core_mem_counter u_pending_writes (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .flush      (1'b0),
        .up         (aw_fire),
        .down       (pending_writes_down),
        .count      (pending_writes),
        .is_zero    (writes_zero),
        .is_full    (writes_full)
    );

endmodule
